rl_ram_1r1w_arbiter: RTL
========================

Name: rl_ram_1r1w_arbiter

Overview:
- Shares one 1R1W RAM (separate read/write ports, byte enables, 1-cycle registered read) between two requesters, m0 and m1.
- Arbitrates the write port and the read port independently with per-port round-robin, so one read and one write can be serviced in the same cycle.
- Resolves same-address read/write hazards.
- Returns read data with a valid strobe to the requester that issued the read.
- Sits between bus-side agents (e.g. CPU and DMA) and the technology RAM wrapper.

Parameters:
- ABITS, 10, address width; RAM depth 2**ABITS.
- DBITS, 32, data width.
- BBITS, (DBITS+7)/8, byte-enable width; derived, not overridden.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- m0_req_i  in  1  m0 request valid.
- m0_we_i  in  1  1=write, 0=read.
- m0_addr_i  in  ABITS  m0 address.
- m0_be_i  in  BBITS  m0 write byte enables.
- m0_wdata_i  in  DBITS  m0 write data.
- m0_gnt_o  out  1  m0 request accepted this cycle.
- m0_rvalid_o  out  1  m0 read data valid.
- m0_rdata_o  out  DBITS  m0 read data.
- m1_*  same set as m0, for requester 1.
- ram_waddr_o  out  ABITS  RAM write address.
- ram_din_o  out  DBITS  RAM write data.
- ram_be_o  out  BBITS  RAM byte enables.
- ram_we_o  out  1  RAM write enable.
- ram_raddr_o  out  ABITS  RAM read address.
- ram_dout_i  in  DBITS  RAM read data, valid 1 cycle after ram_raddr_o.
- busy_o  out  1  arbiter not accepting requests.

Behaviour:
- Clocking/reset: single clock domain; rst_i is synchronous, active-high.
- Reset values:
  - gnt, rvalid, ram_we_o, busy_o = 0 (busy_o = 1 when the optional clear is compiled in).
  - Both round-robin pointers = m0 preferred.
  - hazard flag = 0.
  - ram_* address/data/be outputs = 0.
- Request handshake:
  - A request is held (req, we, addr, be, wdata stable) until gnt=1 in that cycle.
  - Transfer occurs on the req & gnt cycle.
  - Requester may deassert req before grant (request dropped, no side effects).
  - gnt is combinational from req, pointers and state; no combinational path from gnt to req.
- Write port:
  - Candidates are requesters with req & we.
  - One candidate: it is granted.
  - Two candidates: the one indicated by wr_ptr is granted; wr_ptr then flips to the other requester.
  - ram_we_o, ram_waddr_o, ram_din_o, ram_be_o are driven combinationally from the winner in the grant cycle.
  - ram_we_o = 0 when there is no winner.
- Read port:
  - Same round-robin scheme with an independent rd_ptr.
  - ram_raddr_o is driven combinationally from the winner.
- Read return:
  - Registered rd_owner and rd_pending are captured on the read grant.
  - Next cycle: mX_rvalid_o = 1 for the owner only; mX_rdata_o = ram_dout_i.
  - rdata is don't-care when rvalid = 0.
  - Fixed latency of 1 cycle; back-to-back reads are accepted every cycle.
- Hazard (granted read addr == granted write addr, different requesters, same cycle):
  - Default: the write wins and the read is stalled (gnt = 0).
  - The read then observes the new data in a following cycle.
  - hazard flag is set when a read is stalled.
  - If hazard is set and the same hazard recurs, the read wins and the write is stalled. This guarantees no starvation.
  - hazard clears on any cycle without a stall.
  - Pointers update only on actual grants.
- A single requester cannot issue read and write in one cycle (one req per requester).
- busy_o = 1 forces both gnt = 0.
- Reset mid-operation: a pending rvalid is discarded (rvalid = 0 in the cycle after reset), and the ram_we_o from the reset cycle is suppressed.

Optional Feature:
- Macro: RL_RAM_ARB_CLEAR_EN.
- Defined: adds a clear FSM with states CLEAR and RUN.
  - Reset enters CLEAR with counter = 0 and busy_o = 1.
  - Each cycle writes ram_waddr_o = counter, ram_din_o = 0, ram_be_o = all ones, ram_we_o = 1.
  - The counter increments each cycle. After writing address 2**ABITS-1, the FSM goes to RUN and busy_o = 0.
  - Clear takes exactly 2**ABITS cycles; reset during CLEAR restarts from address 0.
- Undefined: no FSM; busy_o is tied 0 and the arbiter is in RUN from the first cycle after reset.

Test Plan:
- Single write then read (ABITS=4, DBITS=32):
  - m0 writes addr 3, data 0xDEADBEEF, be 4'hF -> ram_we_o=1, waddr=3.
  - m0 then reads addr 3 -> next cycle m0_rvalid_o=1, m0_rdata_o=0xDEADBEEF, m1_rvalid_o=0.
- Write contention:
  - m0 and m1 both write (addr 1 and 2) for 4 cycles -> grants alternate m0,m1,m0,m1.
  - Each gnt is held per winner; RAM holds both values.
- Parallel read/write:
  - m0 reads addr 5 while m1 writes addr 6 -> both gnt=1 in the same cycle.
  - m0_rvalid_o=1 next cycle with old addr-5 data.
- Hazard:
  - m1 writes addr 7 = 0x11 while m0 reads addr 7 -> write granted, read stalled.
  - Next cycle the read is granted; rvalid returns 0x11.
  - Continuous m1 writes to addr 7 -> second conflict grants m0's read and stalls m1.
- Byte enables:
  - Write 0xAABBCCDD with be 4'b0101 over 0x00000000 -> read returns 0x00BB00DD.
- Clear (RL_RAM_ARB_CLEAR_EN, ABITS=4):
  - busy_o=1 for exactly 16 cycles; addresses 0..15 are written with 0; no gnt while busy.
  - Reset asserted at cycle 8 -> clear restarts at address 0.

Source files
------------

// File: rtl/rl_ram_1r1w_arbiter.sv
// rl_ram_1r1w_arbiter
//   Shares one 1R1W RAM (registered read, byte-enabled write) between two
//   requesters. The write port and the read port are each arbitrated with
//   their own round-robin pointer, so one read and one write can be serviced
//   in the same cycle. A read and a write to the same address in the same
//   cycle are serialised: the write goes first, and a repeated collision
//   lets the read through, so neither side can be starved.
//
// Optional build macro: RL_RAM_ARB_CLEAR_EN
//   When defined, reset enters a CLEAR state that zeroes every RAM word
//   (one word per cycle, 2**ABITS cycles) with busy_o high, then goes to RUN.
//   When undefined, busy_o is tied low and the arbiter runs right after reset.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   mX_req_i/we_i/addr_i/     request from requester X (held until gnt)
//   mX_be_i/wdata_i
//   mX_gnt_o                  request accepted this cycle (combinational)
//   mX_rvalid_o/rdata_o       read return, one cycle after the read grant
//   ram_waddr_o/din_o/be_o/   RAM write port, driven from the write winner
//   ram_we_o
//   ram_raddr_o               RAM read address, driven from the read winner
//   ram_dout_i                RAM read data, valid one cycle after raddr
//   busy_o                    arbiter not accepting requests
module rl_ram_1r1w_arbiter #(
  parameter  int ABITS = 10,
  parameter  int DBITS = 32,
  localparam int BBITS = (DBITS + 7) / 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             m0_req_i,
  input  logic             m0_we_i,
  input  logic [ABITS-1:0] m0_addr_i,
  input  logic [BBITS-1:0] m0_be_i,
  input  logic [DBITS-1:0] m0_wdata_i,
  output logic             m0_gnt_o,
  output logic             m0_rvalid_o,
  output logic [DBITS-1:0] m0_rdata_o,
  input  logic             m1_req_i,
  input  logic             m1_we_i,
  input  logic [ABITS-1:0] m1_addr_i,
  input  logic [BBITS-1:0] m1_be_i,
  input  logic [DBITS-1:0] m1_wdata_i,
  output logic             m1_gnt_o,
  output logic             m1_rvalid_o,
  output logic [DBITS-1:0] m1_rdata_o,
  output logic [ABITS-1:0] ram_waddr_o,
  output logic [DBITS-1:0] ram_din_o,
  output logic [BBITS-1:0] ram_be_o,
  output logic             ram_we_o,
  output logic [ABITS-1:0] ram_raddr_o,
  input  logic [DBITS-1:0] ram_dout_i,
  output logic             busy_o
);

  localparam int NREQ = 2;

  logic [NREQ-1:0]            req, we;
  logic [NREQ-1:0][ABITS-1:0] addr;
  logic [NREQ-1:0][BBITS-1:0] be;
  logic [NREQ-1:0][DBITS-1:0] wdata;
  logic [NREQ-1:0]            gnt, rvalid;

  assign req   = {m1_req_i,   m0_req_i};
  assign we    = {m1_we_i,    m0_we_i};
  assign addr  = {m1_addr_i,  m0_addr_i};
  assign be    = {m1_be_i,    m0_be_i};
  assign wdata = {m1_wdata_i, m0_wdata_i};

  logic run;

`ifdef RL_RAM_ARB_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t           state;
  logic [ABITS-1:0] clr_cnt;
  logic             busy_q;
  logic             clr_active;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + ABITS'(1);
          if (clr_cnt == '1) begin
            state  <= ST_RUN;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= ST_RUN;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  // The clear write in the reset cycle itself is suppressed.
  assign clr_active = (state == ST_CLEAR) && !rst_i;
`else
  assign busy_o = 1'b0;
`endif

  assign run = !rst_i && !busy_o;

  // Round-robin state and read-return tracking.
  logic wr_ptr, rd_ptr, hazard;
  logic rd_pending, rd_owner;

  // Candidates and per-port winners. A requester issues one op per cycle,
  // so the read winner and write winner are always different requesters.
  logic [NREQ-1:0] wc, rc;
  logic            w_any, r_any, w_sel, r_sel;
  logic            conflict, w_go, r_go;

  assign wc    = req &  we & {NREQ{run}};
  assign rc    = req & ~we & {NREQ{run}};
  assign w_any = |wc;
  assign r_any = |rc;
  assign w_sel = (&wc) ? wr_ptr : wc[1];
  assign r_sel = (&rc) ? rd_ptr : rc[1];

  // Same-address collision: write wins unless the previous cycle already
  // stalled a read on a collision, in which case the read wins.
  assign conflict = w_any && r_any && (addr[w_sel] == addr[r_sel]);
  assign w_go     = w_any && !(conflict &&  hazard);
  assign r_go     = r_any && !(conflict && !hazard);

  always_comb begin
    gnt = '0;
    if (w_go) gnt[w_sel] = 1'b1;
    if (r_go) gnt[r_sel] = 1'b1;
  end

  always_comb begin
    ram_we_o    = w_go;
    ram_waddr_o = w_go ? addr[w_sel]  : '0;
    ram_din_o   = w_go ? wdata[w_sel] : '0;
    ram_be_o    = w_go ? be[w_sel]    : '0;
    ram_raddr_o = r_go ? addr[r_sel]  : '0;
`ifdef RL_RAM_ARB_CLEAR_EN
    if (clr_active) begin
      ram_we_o    = 1'b1;
      ram_waddr_o = clr_cnt;
      ram_din_o   = '0;
      ram_be_o    = '1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      hazard     <= 1'b0;
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      // Pointers move only when an actual contended grant happened.
      if (w_go && (&wc)) wr_ptr <= ~w_sel;
      if (r_go && (&rc)) rd_ptr <= ~r_sel;
      hazard     <= conflict && !r_go;
      rd_pending <= r_go;
      rd_owner   <= r_sel;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_ret
    assign rvalid[i] = rd_pending && (rd_owner == 1'(i));
  end

  assign m0_gnt_o    = gnt[0];
  assign m1_gnt_o    = gnt[1];
  assign m0_rvalid_o = rvalid[0];
  assign m1_rvalid_o = rvalid[1];
  assign m0_rdata_o  = ram_dout_i;
  assign m1_rdata_o  = ram_dout_i;

endmodule
